// File: rtl/spike_pkg.sv
// Shared types and width helpers for the spike ingress path between router and scheduler.
package spike_pkg;

    typedef enum logic [2:0] {
        INIT,
        RUN,
        DRAIN,
        DONE,
        HOLD
    } ingress_state_t;

    // A packet is {axon, tick_offset}; each field is just wide enough to index its range.
    function automatic int pkt_w(input int num_axons, input int num_ticks);
        return $clog2(num_axons) + $clog2(num_ticks);
    endfunction

endpackage

// File: rtl/spike_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit occupancy counter.
module spike_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 12,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scheduler_ingress_buffer.sv
// Buffers router spike packets and issues them as scheduler write strobes, draining on tick advance.
module scheduler_ingress_buffer
    import spike_pkg::*;
#(
    parameter  int NUM_AXONS  = 256,
    parameter  int NUM_TICKS  = 16,
    parameter  int FIFO_DEPTH = 16,
    localparam int PKT_W      = pkt_w(NUM_AXONS, NUM_TICKS),
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PKT_W-1:0] in_packet,
    output logic             in_ready,
    input  logic             sched_busy,
    output logic             out_wen,
    output logic [PKT_W-1:0] out_packet,
    input  logic             tick_req,
    output logic             tick_done,
    output logic [CW-1:0]    count
);

    ingress_state_t state;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    // in_ready looks at the pre-pop count, so a full buffer refuses a push even while popping.
    assign in_ready = (state == RUN) && !fifo_full && !tick_req;
    assign push     = in_valid && in_ready;
    assign out_wen  = !fifo_empty && !sched_busy && ((state == RUN) || (state == DRAIN));
    assign pop      = out_wen;

    spike_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_packet),
        .pop       (pop),
        .head      (out_packet),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // tick_done is registered alongside the DRAIN->DONE transition so it is high exactly in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            tick_done <= 1'b0;
        end else begin
            tick_done <= 1'b0;
            unique case (state)
                INIT: begin
                    if (!sched_busy) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (tick_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !pop) begin
                        state     <= DONE;
                        tick_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (!tick_req) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scheduler_ingress_buffer.sv
// Directed bench for scheduler_ingress_buffer: vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_scheduler_ingress_buffer;

    localparam int PKT_W = 12;
    localparam int CW    = 5;

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    logic             in_valid   = 1'b0;
    logic [PKT_W-1:0] in_packet  = '0;
    logic             sched_busy = 1'b0;
    logic             tick_req   = 1'b0;
    logic             in_ready;
    logic             out_wen;
    logic [PKT_W-1:0] out_packet;
    logic             tick_done;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;
    int pushes   = 0;
    int pops     = 0;
    logic [PKT_W-1:0] exp_q [$];

    typedef struct {
        logic             v;
        logic [PKT_W-1:0] pkt;
        logic             busy;
        logic             treq;
        logic             rdy;
        logic             wen;
        logic [PKT_W-1:0] opkt;
        logic [CW-1:0]    cnt;
        logic             td;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    // Per-cycle patterns for the stalled drain, indexed by cycle number after tick_req rises.
    logic [10:0] stall_busy = 11'h03C;
    logic [10:0] stall_wen  = 11'h0C2;
    logic [10:0] stall_td   = 11'h200;

    scheduler_ingress_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_packet  (in_packet),
        .in_ready   (in_ready),
        .sched_busy (sched_busy),
        .out_wen    (out_wen),
        .out_packet (out_packet),
        .tick_req   (tick_req),
        .tick_done  (tick_done),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference FIFO: records accepted packets and checks every issued write in order.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_wen) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("write_with_empty_model", 32'(out_wen), 32'd0);
                end else begin
                    check("order", 32'(out_packet), 32'(exp_q[0]));
                    exp_q.delete(0);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_packet);
                pushes++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 12'hA32, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[1]  = '{1'b1, 12'h05F, 1'b0, 1'b0, 1'b1, 1'b1, 12'hA32, 5'd1, 1'b0};
        vecs[2]  = '{1'b1, 12'hFF0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h05F, 5'd1, 1'b0};
        vecs[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFF0, 5'd1, 1'b0};
        vecs[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[5]  = '{1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[6]  = '{1'b1, 12'h456, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd1, 1'b0};
        vecs[7]  = '{1'b1, 12'h789, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd2, 1'b0};
        vecs[8]  = '{1'b1, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 5'd3, 1'b0};
        vecs[9]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 5'd3, 1'b0};
        vecs[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 12'h456, 5'd2, 1'b0};
        vecs[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 12'h789, 5'd1, 1'b0};
        vecs[12] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[13] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 5'd0, 1'b1};
        vecs[14] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[15] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[16] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[17] = '{1'b1, 12'h5A5, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
        vecs[18] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h5A5, 5'd1, 1'b0};
        vecs[19] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};

        // Reset state, then scheduler init sweep with the router already offering a packet.
        rst        = 1'b0;
        sched_busy = 1'b1;
        step();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_wen", 32'(out_wen), 32'd0);
        check("reset_tick_done", 32'(tick_done), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        step();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_packet = 12'h777;
        for (int i = 0; i < 15; i++) begin
            #1;
            check($sformatf("init_in_ready_c%0d", i), 32'(in_ready), 32'd0);
            step();
        end
        sched_busy = 1'b0;
        in_valid   = 1'b0;
        #1;
        check("init_busy_fall_in_ready", 32'(in_ready), 32'd0);
        step();

        // Streaming and tick drain vectors.
        for (int i = 0; i < NVEC; i++) begin
            in_valid   = vecs[i].v;
            in_packet  = vecs[i].pkt;
            sched_busy = vecs[i].busy;
            tick_req   = vecs[i].treq;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_out_wen", i), 32'(out_wen), 32'(vecs[i].wen));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_tick_done", i), 32'(tick_done), 32'(vecs[i].td));
            if (vecs[i].wen) begin
                check($sformatf("vec%0d_out_packet", i), 32'(out_packet), 32'(vecs[i].opkt));
            end
            step();
        end

        // Fill to full while the scheduler is busy.
        sched_busy = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_packet = 12'(12'h100 + i);
            #1;
            check($sformatf("fill_in_ready_%0d", i), 32'(in_ready), 32'd1);
            step();
        end
        in_packet = 12'h110;
        #1;
        check("full_count", 32'(count), 32'd16);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_wen", 32'(out_wen), 32'd0);
        step();
        sched_busy = 1'b0;
        #1;
        check("full_release_count", 32'(count), 32'd16);
        check("full_release_in_ready", 32'(in_ready), 32'd0);
        check("full_release_out_wen", 32'(out_wen), 32'd1);
        step();
        for (int j = 0; j < 4; j++) begin
            in_packet = 12'(12'h110 + j);
            #1;
            check($sformatf("pushpop_in_ready_%0d", j), 32'(in_ready), 32'd1);
            check($sformatf("pushpop_count_%0d", j), 32'(count), 32'd15);
            step();
        end
        in_valid = 1'b0;
        begin
            int budget = 0;
            while (count != 0 && budget < 40) begin
                step();
                budget++;
            end
        end
        check("full_drain_count", 32'(count), 32'd0);
        check("full_drain_model_empty", 32'(exp_q.size()), 32'd0);
        check("full_drain_balance", 32'(pops), 32'(pushes));

        // Drain stalled by a 4-cycle sched_busy pulse.
        sched_busy = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_packet = 12'(12'h201 + i);
            step();
        end
        in_valid = 1'b0;
        tick_req = 1'b1;
        #1;
        check("stall_req_in_ready", 32'(in_ready), 32'd0);
        step();
        for (int d = 1; d <= 10; d++) begin
            sched_busy = stall_busy[d];
            #1;
            check($sformatf("stall_out_wen_d%0d", d), 32'(out_wen), 32'(stall_wen[d]));
            check($sformatf("stall_tick_done_d%0d", d), 32'(tick_done), 32'(stall_td[d]));
            step();
        end
        tick_req = 1'b0;
        #1;
        check("hold_release_in_ready", 32'(in_ready), 32'd0);
        step();
        check("back_to_run_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset with a stalled drain holding five packets.
        sched_busy = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_packet = 12'(12'h301 + i);
            step();
        end
        in_valid = 1'b0;
        tick_req = 1'b1;
        step();
        check("prereset_count", 32'(count), 32'd5);
        sched_busy = 1'b0;
        #1;
        check("prereset_out_wen", 32'(out_wen), 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_out_wen", 32'(out_wen), 32'd0);
        check("async_reset_tick_done", 32'(tick_done), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd0);
        tick_req   = 1'b0;
        sched_busy = 1'b1;
        step();
        step();
        rst      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("reinit_in_ready_%0d", i), 32'(in_ready), 32'd0);
            step();
        end

        // tick_req raised during INIT goes straight to DRAIN on the first RUN cycle.
        in_valid   = 1'b0;
        tick_req   = 1'b1;
        sched_busy = 1'b0;
        #1;
        check("init_req_e0_in_ready", 32'(in_ready), 32'd0);
        step();
        check("init_req_e1_in_ready", 32'(in_ready), 32'd0);
        check("init_req_e1_tick_done", 32'(tick_done), 32'd0);
        step();
        check("init_req_e2_tick_done", 32'(tick_done), 32'd0);
        step();
        check("init_req_e3_tick_done", 32'(tick_done), 32'd1);
        step();
        tick_req = 1'b0;
        #1;
        check("init_req_e4_tick_done", 32'(tick_done), 32'd0);
        check("init_req_e4_in_ready", 32'(in_ready), 32'd0);
        step();
        check("init_req_e5_in_ready", 32'(in_ready), 32'd1);
        check("final_model_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
